// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared FSM encoding, agent count and count width for the simulation controller
package sim_pkg;

  localparam int NUM_AGENTS = 10;
  localparam int CNT_W      = 4;
  localparam int ADDR_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SAMPLE,
    REPORT,
    STEP,
    FINISH
  } state_t;

endpackage

// File: rtl/popcount10.sv
// rtl/popcount10.sv - population count of a 10-bit agent state vector
module popcount10
  import sim_pkg::*;
(
  input  logic [9:0]       bits,
  output logic [CNT_W-1:0] count
);

  // Sum of set bits; at most 10, so it always fits the 4-bit count.
  always_comb begin
    count = '0;
    for (int i = 0; i < 10; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/sim_controller.sv
// rtl/sim_controller.sv - agent-array run controller: load, sample, report, step (optional PEAK_TRACK_EN peak tracking)
module sim_controller
  import sim_pkg::*;
#(
  parameter int NUM_AGENTS = sim_pkg::NUM_AGENTS,
  parameter int STEP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STEP_W-1:0]     numSteps,
  input  logic [NUM_AGENTS-1:0] initVector,
  output logic                  loadState,
  output logic [ADDR_W-1:0]     address,
  output logic                  initState,
  input  logic [NUM_AGENTS-1:0] currStates,
  output logic                  stepEnable,
  output logic                  statValid,
  input  logic                  statReady,
  output logic [STEP_W-1:0]     statStep,
  output logic [CNT_W-1:0]      statCount,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      peakCount,
  output logic [STEP_W-1:0]     peakStep
);

  state_t                  state;
  state_t                  state_nxt;
  logic [STEP_W-1:0]       step_cnt;
  logic [STEP_W-1:0]       num_steps_q;
  logic [NUM_AGENTS-1:0]   init_vec_q;
  logic [ADDR_W-1:0]       load_idx;
  logic [CNT_W-1:0]        pop_count;
  logic [9:0]              pop_in;
  logic                    accept;
  logic                    last_load;
  logic                    run_end;

  assign pop_in    = 10'(currStates);
  assign accept    = (state == IDLE) && start;
  assign last_load = (load_idx == ADDR_W'(NUM_AGENTS - 1));
  // A run ends at the requested step or as soon as no agent is infected.
  assign run_end   = (step_cnt == num_steps_q) || (statCount == '0);
  assign address   = load_idx;
  assign initState = init_vec_q[load_idx];

  popcount10 u_popcount (
    .bits  (pop_in),
    .count (pop_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobes; abort overrides everything outside IDLE, including a same-cycle handshake.
  always_comb begin
    state_nxt  = state;
    loadState  = 1'b0;
    stepEnable = 1'b0;
    statValid  = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        loadState = 1'b1;
        if (last_load) state_nxt = SAMPLE;
      end
      SAMPLE:  state_nxt = REPORT;
      REPORT: begin
        statValid = 1'b1;
        if (statReady) state_nxt = run_end ? FINISH : STEP;
      end
      STEP: begin
        stepEnable = 1'b1;
        state_nxt  = SAMPLE;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt  = IDLE;
      loadState  = 1'b0;
      stepEnable = 1'b0;
      statValid  = 1'b0;
      done       = 1'b0;
    end
  end

  // Run parameters, load index, step counter and the registered per-step statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_steps_q <= '0;
      init_vec_q  <= '0;
      load_idx    <= '0;
      step_cnt    <= '0;
      statStep    <= '0;
      statCount   <= '0;
    end else if (accept) begin
      num_steps_q <= numSteps;
      init_vec_q  <= initVector;
      load_idx    <= '0;
      step_cnt    <= '0;
    end else if (!abort) begin
      if (state == LOAD) begin
        load_idx <= load_idx + 1'b1;
      end
      if (state == SAMPLE) begin
        statStep  <= step_cnt;
        statCount <= pop_count;
      end
      if (state == STEP) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

`ifdef PEAK_TRACK_EN
  // Highest count seen in the run; strict compare keeps the earliest step on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peakCount <= '0;
      peakStep  <= '0;
    end else if (accept) begin
      peakCount <= '0;
      peakStep  <= '0;
    end else if ((state == SAMPLE) && !abort && (pop_count > peakCount)) begin
      peakCount <= pop_count;
      peakStep  <= step_cnt;
    end
  end
`else
  assign peakCount = '0;
  assign peakStep  = '0;
`endif

endmodule
